// File: rtl/cpu_imem_arbiter_pkg.sv
// Purpose: shared types for the instruction-memory arbiter (word type, read-owner tag).
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
package cpu_imem_arbiter_pkg;

  typedef logic [31:0] word_t;

  // Which requester owns the read issued last cycle; steers the returned data.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DBG  = 2'd2
  } imem_owner_t;

  // Starvation counter width; a MAX_STARVE of 0 still needs one bit so the
  // vector is legal (it simply never leaves 0).
  function automatic int unsigned starve_cnt_width(input int unsigned max_starve);
    return (max_starve == 0) ? 1 : $clog2(max_starve + 1);
  endfunction

endpackage

// File: rtl/cpu_imem_arbiter.sv
// Purpose: shares one synchronous imem port between IF fetch and a debug/loader port.
// Latency: grant is combinational; read data returns exactly 1 cycle after grant.
// Backpressure: fetch loses contention via if_stall_o; debug waits on dbg_gnt_o, force-granted after MAX_STARVE denials.
//
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   if_req_i/if_addr_i             fetch request and address
//   if_stall_o                     fetch requested but not granted this cycle
//   if_data_o/if_valid_o           fetch read response (1 cycle after grant)
//   dbg_req_i/dbg_we_i/dbg_addr_i/dbg_wdata_i   debug access, held until granted
//   dbg_gnt_o                      debug access performed this cycle
//   dbg_rdata_o/dbg_rvalid_o       debug read response (1 cycle after grant)
//   mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i  RAM port (1-cycle read latency)
module cpu_imem_arbiter
  import cpu_imem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 8
) (
  input  logic  clk_i,
  input  logic  reset_i,

  input  logic  if_req_i,
  input  word_t if_addr_i,
  output logic  if_stall_o,
  output word_t if_data_o,
  output logic  if_valid_o,

  input  logic  dbg_req_i,
  input  logic  dbg_we_i,
  input  word_t dbg_addr_i,
  input  word_t dbg_wdata_i,
  output logic  dbg_gnt_o,
  output word_t dbg_rdata_o,
  output logic  dbg_rvalid_o,

  output word_t mem_addr_o,
  output logic  mem_we_o,
  output word_t mem_wdata_o,
  input  word_t mem_rdata_i
);

  localparam int unsigned          CNT_W   = starve_cnt_width(MAX_STARVE);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_STARVE);

  imem_owner_t      owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic dbg_force;
  logic dbg_gnt;
  logic if_gnt;

  // Grant: fetch wins contention unless debug has been denied MAX_STARVE
  // times in a row. With MAX_STARVE == 0 the counter sits at 0 == CNT_MAX,
  // so debug always wins.
  always_comb begin
    dbg_force = (starve_cnt_q == CNT_MAX);
    dbg_gnt   = dbg_req_i & (~if_req_i | dbg_force);
    if_gnt    = if_req_i & ~dbg_gnt;
  end

  // Next-state for owner tag and starvation counter.
  always_comb begin
    owner_d      = OWN_NONE;
    starve_cnt_d = '0;

    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (dbg_gnt && !dbg_we_i) begin
      owner_d = OWN_DBG;
    end

    // A denial implies the counter is below CNT_MAX, but saturate anyway so
    // the counter can never wrap back to 0 under a pending request.
    if (dbg_req_i && !dbg_gnt) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q
                                               : starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Memory drive: only a debug grant may write; otherwise present the fetch
  // address so an idle port still looks like a harmless read.
  always_comb begin
    mem_addr_o  = dbg_gnt ? dbg_addr_i : if_addr_i;
    mem_we_o    = dbg_gnt & dbg_we_i;
    mem_wdata_o = dbg_gnt ? dbg_wdata_i : '0;
  end

  assign dbg_gnt_o    = dbg_gnt;
  assign if_stall_o   = if_req_i & ~if_gnt;

  // Both data outputs are plain passthroughs; the owner tag says whose it is.
  assign if_data_o    = mem_rdata_i;
  assign dbg_rdata_o  = mem_rdata_i;
  assign if_valid_o   = (owner_q == OWN_IF);
  assign dbg_rvalid_o = (owner_q == OWN_DBG);

endmodule

// File: tb/tb_cpu_imem_arbiter.sv
module tb_cpu_imem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic        ram_load;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;

  // Instance 0: MAX_STARVE = 8, instance 1: MAX_STARVE = 0. Same stimulus.
  logic [1:0]        if_stall_w, if_valid_w, dbg_gnt_w, dbg_rvalid_w, mem_we_w;
  logic [1:0][31:0]  if_data_w, dbg_rdata_w, mem_addr_w, mem_wdata_w, mem_rdata_w;

  cpu_imem_arbiter #(.MAX_STARVE(8)) dut0 (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_stall_o(if_stall_w[0]), .if_data_o(if_data_w[0]), .if_valid_o(if_valid_w[0]),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt_w[0]), .dbg_rdata_o(dbg_rdata_w[0]), .dbg_rvalid_o(dbg_rvalid_w[0]),
    .mem_addr_o(mem_addr_w[0]), .mem_we_o(mem_we_w[0]), .mem_wdata_o(mem_wdata_w[0]),
    .mem_rdata_i(mem_rdata_w[0])
  );

  cpu_imem_arbiter #(.MAX_STARVE(0)) dut1 (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_stall_o(if_stall_w[1]), .if_data_o(if_data_w[1]), .if_valid_o(if_valid_w[1]),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt_w[1]), .dbg_rdata_o(dbg_rdata_w[1]), .dbg_rvalid_o(dbg_rvalid_w[1]),
    .mem_addr_o(mem_addr_w[1]), .mem_we_o(mem_we_w[1]), .mem_wdata_o(mem_wdata_w[1]),
    .mem_rdata_i(mem_rdata_w[1])
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Write-first synchronous RAMs, one per instance, 256 words indexed by addr[9:2].
  logic [31:0] ram [2][256];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_load) begin
        for (int i = 0; i < 256; i++) ram[k][i] <= init_val(i);
      end else begin
        if (mem_we_w[k]) ram[k][mem_addr_w[k][9:2]] <= mem_wdata_w[k];
        mem_rdata_w[k] <= mem_we_w[k] ? mem_wdata_w[k] : ram[k][mem_addr_w[k][9:2]];
      end
    end
  end

  // Reference model state: contents of memory, response expected next cycle,
  // and how many consecutive cycles a pending debug request has been refused.
  logic [31:0] gold [2][256];
  bit          exp_ifv [2];
  bit          exp_dv  [2];
  logic [31:0] exp_data[2];
  int          streak  [2];
  int          max_s   [2];
  bit          obs_dgnt[2];
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_ifv[k] = 1'b0;
      exp_dv[k]  = 1'b0;
      streak[k]  = 0;
    end
  endtask

  // Registered side: responses to last cycle's grants.
  task automatic edge_check();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("if_valid[%0d]", k),   32'(if_valid_w[k]),   32'(exp_ifv[k]));
      chk($sformatf("dbg_rvalid[%0d]", k), 32'(dbg_rvalid_w[k]), 32'(exp_dv[k]));
      if (exp_ifv[k]) chk($sformatf("if_data[%0d]", k),   if_data_w[k],   exp_data[k]);
      if (exp_dv[k])  chk($sformatf("dbg_rdata[%0d]", k), dbg_rdata_w[k], exp_data[k]);
    end
  endtask

  // Combinational side: apply inputs, check grant and memory drive, advance model.
  task automatic drive_check(input bit ireq, input logic [31:0] iaddr,
                             input bit dreq, input bit dwe,
                             input logic [31:0] daddr, input logic [31:0] dwd);
    bit dg, ig;
    if_req = ireq; if_addr = iaddr;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    #1;
    for (int k = 0; k < 2; k++) begin
      dg = dreq && (!ireq || streak[k] >= max_s[k]);
      ig = ireq && !dg;
      obs_dgnt[k] = dbg_gnt_w[k];
      chk($sformatf("dbg_gnt[%0d]", k),   32'(dbg_gnt_w[k]),  32'(dg));
      chk($sformatf("if_stall[%0d]", k),  32'(if_stall_w[k]), 32'(ireq && !ig));
      chk($sformatf("mem_addr[%0d]", k),  mem_addr_w[k],      dg ? daddr : iaddr);
      chk($sformatf("mem_we[%0d]", k),    32'(mem_we_w[k]),   32'(dg && dwe));
      chk($sformatf("mem_wdata[%0d]", k), mem_wdata_w[k],     dg ? dwd : 32'h0);
      exp_ifv[k]  = ig;
      exp_dv[k]   = dg && !dwe;
      exp_data[k] = ig ? gold[k][iaddr[9:2]] : gold[k][daddr[9:2]];
      if (dg && dwe) gold[k][daddr[9:2]] = dwd;
      if (dreq && !dg) streak[k] = (streak[k] + 1 > max_s[k]) ? max_s[k] : streak[k] + 1;
      else             streak[k] = 0;
      if (reset_i) begin
        exp_ifv[k] = 1'b0;
        exp_dv[k]  = 1'b0;
        streak[k]  = 0;
      end
    end
  endtask

  task automatic step(input bit ireq, input logic [31:0] iaddr,
                      input bit dreq, input bit dwe,
                      input logic [31:0] daddr, input logic [31:0] dwd);
    edge_check();
    drive_check(ireq, iaddr, dreq, dwe, daddr, dwd);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a = a & 32'h0000_03FC;
    return a;
  endfunction

  initial begin
    bit          r_dreq, r_dwe, r_ireq;
    logic [31:0] r_daddr, r_dwd, r_iaddr;

    checks = 0; errors = 0;
    max_s[0] = 8; max_s[1] = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) gold[k][i] = init_val(i);
    end
    model_reset();

    reset_i = 1'b1; ram_load = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_if_valid[%0d]", k),   32'(if_valid_w[k]),   32'h0);
      chk($sformatf("reset_dbg_rvalid[%0d]", k), 32'(dbg_rvalid_w[k]), 32'h0);
    end
    ram_load = 1'b0;
    reset_i  = 1'b0;

    // Fetch only, consecutive words.
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Debug write then read back while fetch is idle.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("dbg_readback", dbg_rdata_w[0], 32'hDEADBEEF);

    // Sustained contention: instance 0 yields on the 9th cycle, instance 1 at once.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0);
      chk($sformatf("contend_gnt0_c%0d", i),   32'(obs_dgnt[0]),   32'(i == 8));
      chk($sformatf("contend_stall0_c%0d", i), 32'(if_stall_w[0]), 32'(i == 8));
      chk($sformatf("contend_gnt1_c%0d", i),   32'(obs_dgnt[1]),   32'h1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Self-modifying code: write then fetch of the same word.
    step(1'b0, 32'h0,  1'b1, 1'b1, 32'h20, 32'h0000_0013);
    step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0);
    step(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0);
    chk("smc_data0", if_data_w[0], 32'h0000_0013);
    chk("smc_data1", if_data_w[1], 32'h0000_0013);

    // Build partial starvation, then a fetch read, then reset mid-response.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0);
    step(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
    edge_check();
    chk("pre_reset_if_valid0", 32'(if_valid_w[0]), 32'h1);
    reset_i = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_rst_if_valid[%0d]", k),   32'(if_valid_w[k]),   32'h0);
      chk($sformatf("async_rst_dbg_rvalid[%0d]", k), 32'(dbg_rvalid_w[k]), 32'h0);
    end
    drive_check(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    edge_check();
    reset_i = 1'b0;
    drive_check(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Counter must restart from 0: full 8 denials again before debug wins.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h48, 1'b1, 1'b0, 32'h84, 32'h0);
      chk($sformatf("post_rst_gnt0_c%0d", i), 32'(obs_dgnt[0]), 32'(i == 8));
    end

    // Randomised traffic; debug request mostly held until granted by instance 0.
    r_dreq = 1'b0; r_dwe = 1'b0; r_daddr = '0; r_dwd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!r_dreq || obs_dgnt[0] || $urandom_range(0, 15) == 0) begin
        r_dreq  = ($urandom_range(0, 2) != 0);
        r_dwe   = ($urandom_range(0, 3) == 0);
        r_daddr = rand_addr();
        r_dwd   = $urandom;
      end
      r_ireq  = ($urandom_range(0, 5) != 0);
      r_iaddr = rand_addr();
      step(r_ireq, r_iaddr, r_dreq, r_dwe, r_daddr, r_dwd);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    edge_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_imem_arbiter.md
Name: cpu_imem_arbiter

Overview:
Shares the single synchronous instruction-memory port between the CPU instruction-fetch stage and a debug/loader requester. The debug/loader requester can read or write program memory while the core runs or is halted.
- Fetch has priority, but a bounded starvation counter guarantees debug progress.
- Sits between the IF stage's imem address/data pins and the instruction RAM.
- Tracks which requester owns the in-flight read so returned data is steered correctly.

Parameters:
MAX_STARVE, 8, consecutive cycles a pending debug request may be denied before it is force-granted over fetch; 0 = debug always wins contention.

Ports:
clk_i  input  1  clock
reset_i  input  1  reset, asynchronous, active-high
if_req_i  input  1  fetch wants memory this cycle (driven low while halted)
if_addr_i  input  32  fetch address (word_t)
if_stall_o  output  1  combinational; high when if_req_i is high but fetch is not granted; IF treats this as not-ready and holds its PC
if_data_o  output  32  read data (mem_rdata_i passthrough)
if_valid_o  output  1  if_data_o holds the response to fetch granted last cycle
dbg_req_i  input  1  debug access request; held with addr/wdata/we stable until granted
dbg_we_i  input  1  1 = write, 0 = read
dbg_addr_i  input  32  debug address
dbg_wdata_i  input  32  debug write data
dbg_gnt_o  output  1  combinational grant; access is performed this cycle
dbg_rdata_o  output  32  read data (mem_rdata_i passthrough)
dbg_rvalid_o  output  1  dbg_rdata_o holds the response to the debug read granted last cycle
mem_addr_o  output  32  memory address
mem_we_o  output  1  memory write enable
mem_wdata_o  output  32  memory write data
mem_rdata_i  input  32  memory read data; 1-cycle latency after address

Behaviour:
- Grant each cycle, combinational:
  - Neither requests: no grant.
  - Only fetch requests: grant fetch.
  - Only debug requests: grant debug.
  - Both request: grant debug if starve_cnt >= MAX_STARVE; otherwise grant fetch.
- Memory drive:
  - Debug granted: mem_addr_o = dbg_addr_i, mem_we_o = dbg_we_i, mem_wdata_o = dbg_wdata_i.
  - Any other case: mem_addr_o = if_addr_i, mem_we_o = 0, mem_wdata_o = 0.
  - Address passes through unmodified; no alignment checks.
- mem_we_o is never high unless dbg_gnt_o is high.
- Owner register (imem_owner_t), updated on posedge clk_i:
  - OWN_IF if fetch granted.
  - OWN_DBG if debug read granted.
  - OWN_NONE for no grant or for a debug write.
- Response outputs:
  - if_valid_o = (owner == OWN_IF); dbg_rvalid_o = (owner == OWN_DBG).
  - Both valids are never high together.
  - Grant-to-data latency is exactly 1 cycle.
- starve_cnt, width $clog2(MAX_STARVE+1):
  - Increments, saturating at MAX_STARVE, when dbg_req_i is high and not granted.
  - Clears to 0 when debug is granted or dbg_req_i is low.
- Fetch can therefore be stalled at most 1 cycle per MAX_STARVE+1 cycles of contention.
- A debug write followed next cycle by a fetch of the same address returns the new data (RAM is write-first); the arbiter adds no forwarding.
- Reset (async, any time): owner = OWN_NONE, starve_cnt = 0, if_valid_o = 0, dbg_rvalid_o = 0.
  - An in-flight read is discarded with no valid pulse.
  - Grants are still combinational during reset, but IF drives if_req_i low and no state advances.
- Protocol violation (dbg_req_i dropped before grant): no access is performed and the counter clears; not flagged.

Decomposition:
- common package: imem_owner_t enum {OWN_NONE, OWN_IF, OWN_DBG}.
- Reuse word_t from common.
- No sub-module required. The grant/starvation logic may optionally be factored into cpu_starve_counter (inputs: pending, granted; output: force).

Test Plan:
- Fetch only: if_req_i=1, addr 0x0,0x4,0x8 on consecutive cycles -> if_stall_o=0 throughout, if_valid_o=1 each following cycle, data = RAM[0], RAM[4], RAM[8]; dbg_rvalid_o=0.
- Debug write then read while fetch idle: write 0xDEADBEEF to 0x100, then read 0x100 -> dbg_gnt_o=1 both cycles, no rvalid after the write, dbg_rvalid_o=1 with 0xDEADBEEF one cycle after the read grant.
- Contention, MAX_STARVE=8: fetch and debug read both held high -> fetch granted cycles 0-7; debug granted cycle 8 with if_stall_o=1 that cycle; counter back to 0; fetch granted cycle 9.
- MAX_STARVE=0 contention: both requesting -> debug granted immediately, if_stall_o=1 for that cycle only.
- Self-modifying code: debug write 0x00000013 to 0x20 granted cycle N, fetch 0x20 granted cycle N+1 -> if_data_o=0x00000013 at cycle N+2.
- Async reset mid-read: fetch granted, reset_i pulsed before the next clock edge -> if_valid_o=0 immediately, owner=OWN_NONE, starve_cnt=0 after deassertion.
